// File: rtl/program_loader.sv
// program_loader: receives a framed byte stream, writes big-endian words to instruction memory, holds the CPU in reset until the checksum verifies
// Ports: clk/reset (sync, active-low); in_data/in_valid/in_ready byte stream in;
//        mem_addr/mem_wdata/mem_we memory write side; cpu_reset to OSECPU;
//        busy/done/error/err_code status (err_code 1 count too big, 2 checksum, 3 timeout)
module program_loader #(
  parameter int ADDR_W = 16,
  parameter int MAX_WORDS = 1024,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, CNT_LO, DATA, WRITE, CSUM, DONE, ERR} state_t;
  state_t state, nxt;
  logic [1:0] nxt_code;
  logic [7:0] cnt_hi, acc;
  logic [15:0] n_words, n_in;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0] byte_idx;
  logic [31:0] word;
  logic [TO_W-1:0] to_cnt;
  logic xfer, counting, to_hit, last_word;
  assign xfer = in_valid && in_ready;
  assign counting = state inside {CNT_LO, DATA, CSUM};
  // a transfer in the same cycle as expiry wins
  assign to_hit = counting && !xfer && to_cnt == TO_W'(TIMEOUT_CYCLES - 1);
  assign n_in = {cnt_hi, in_data};
  assign last_word = 32'(word_idx) + 32'd1 == 32'(n_words);
  assign mem_addr = word_idx;
  assign mem_wdata = word;
  always_comb begin
    nxt = state;
    nxt_code = err_code;
    case (state)
      IDLE: if (xfer) nxt = CNT_LO;
      CNT_LO: if (xfer) begin
        nxt = 32'(n_in) > MAX_WORDS ? ERR : n_in == 16'd0 ? CSUM : DATA;
        nxt_code = 32'(n_in) > MAX_WORDS ? 2'd1 : err_code;
      end
      DATA: if (xfer && byte_idx == 2'd3) nxt = WRITE;
      WRITE: nxt = last_word ? CSUM : DATA;
      CSUM: if (xfer) begin
        nxt = (acc ^ in_data) == 8'd0 ? DONE : ERR;
        nxt_code = (acc ^ in_data) == 8'd0 ? err_code : 2'd2;
      end
      default: ;
    endcase
    if (to_hit) begin
      nxt = ERR;
      nxt_code = 2'd3;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      err_code <= 2'd0;
      cnt_hi <= 8'd0;
      acc <= 8'd0;
      n_words <= 16'd0;
      word_idx <= '0;
      byte_idx <= 2'd0;
      word <= 32'd0;
      to_cnt <= '0;
      in_ready <= 1'b1;
      mem_we <= 1'b0;
      cpu_reset <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= nxt;
      err_code <= nxt_code;
      to_cnt <= xfer ? '0 : counting ? to_cnt + TO_W'(1) : to_cnt;
      if (xfer) acc <= state == IDLE ? in_data : acc ^ in_data;
      if (xfer && state == IDLE) cnt_hi <= in_data;
      if (xfer && state == CNT_LO) begin
        n_words <= n_in;
        word_idx <= '0;
        byte_idx <= 2'd0;
      end
      // byte_idx wraps to 0 on the 4th byte, ready for the next word
      if (xfer && state == DATA) begin
        word <= {word[23:0], in_data};
        byte_idx <= byte_idx + 2'd1;
      end
      if (state == WRITE) word_idx <= word_idx + ADDR_W'(1);
      // outputs registered from the next state so they align with it
      in_ready <= nxt inside {IDLE, CNT_LO, DATA, CSUM};
      mem_we <= nxt == WRITE;
      cpu_reset <= nxt != DONE;
      busy <= nxt inside {CNT_LO, DATA, WRITE, CSUM};
      done <= nxt == DONE;
      error <= nxt == ERR;
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed bench for program_loader
module tb_program_loader;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_ready;
  logic [7:0] in_data = 8'd0;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic mem_we, cpu_reset, busy, done, error;
  logic [1:0] err_code;
  int checks = 0, errors = 0, cyc = 0, last = 0, nw = 0, rdy_low = 0, rdy_bad = 0;
  logic [15:0] wa [16];
  logic [31:0] wd [16];
  logic [7:0] frm [14] = '{8'h00, 8'h03, 8'h02, 8'h00, 8'h00, 8'h05, 8'h02, 8'h04, 8'h00, 8'h03, 8'hD3, 8'h00, 8'h00, 8'h00};
  logic [31:0] exp_w [3] = '{32'h02000005, 32'h02040003, 32'hD3000000};
  program_loader #(.ADDR_W(16), .MAX_WORDS(1024), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .cpu_reset(cpu_reset),
    .busy(busy), .done(done), .error(error), .err_code(err_code));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mem_we) begin
      wa[nw % 16] = mem_addr;
      wd[nw % 16] = mem_wdata;
      nw++;
    end
    if (busy && !in_ready) rdy_low++;
    if (busy && in_ready === mem_we) rdy_bad++;
  end
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic send(input logic [7:0] b, input bit gap);
    int n = 0;
    @(negedge clk);
    in_data = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_wait in_ready got 0 want 1 byte %h", b);
    end
    @(posedge clk);
    #1 last = cyc;
    if (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask
  function automatic logic [7:0] good_csum();
    logic [7:0] x = 8'd0;
    for (int i = 0; i < 14; i++) x ^= frm[i];
    return x;
  endfunction
  task automatic send_frame(input bit gap, input logic [7:0] csum);
    for (int i = 0; i < 14; i++) send(frm[i], gap);
    checks++;
    if (cpu_reset !== 1'b1) begin errors++; $display("FAIL pre_csum_cpu_reset got %b want 1", cpu_reset); end
    send(csum, gap);
    if (!gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask
  task automatic check_writes(input string tag, input int b);
    checks++;
    if (nw - b !== 3) begin errors++; $display("FAIL %s write_count got %0d want 3", tag, nw - b); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wa[(b + i) % 16] !== 16'(i) || wd[(b + i) % 16] !== exp_w[i])
        begin errors++; $display("FAIL %s write%0d got %h:%h want %h:%h", tag, i, wa[(b + i) % 16], wd[(b + i) % 16], 16'(i), exp_w[i]); end
    end
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({in_ready, mem_we, cpu_reset, busy, done, error} !== 6'b101000 || mem_addr !== 16'd0 || mem_wdata !== 32'd0 || err_code !== 2'd0)
      begin errors++; $display("FAIL reset_outputs got rdy%b we%b cr%b bz%b dn%b er%b a%h d%h c%0d want 101000 0 0 0", in_ready, mem_we, cpu_reset, busy, done, error, mem_addr, mem_wdata, err_code); end
  endtask
  task automatic test_load(input bit gap);
    int b, rl, rb;
    do_reset();
    b = nw; rl = rdy_low; rb = rdy_bad;
    send_frame(gap, good_csum());
    check_writes(gap ? "toggle" : "held", b);
    checks++;
    if ({done, error, cpu_reset, busy} !== 4'b1000) begin errors++; $display("FAIL load_status got dn%b er%b cr%b bz%b want 1000", done, error, cpu_reset, busy); end
    checks++;
    if (rdy_low - rl !== 3) begin errors++; $display("FAIL ready_low_cycles got %0d want 3", rdy_low - rl); end
    checks++;
    if (rdy_bad - rb !== 0) begin errors++; $display("FAIL ready_vs_write got %0d want 0", rdy_bad - rb); end
  endtask
  task automatic test_bad_csum();
    int b;
    do_reset();
    b = nw;
    send_frame(1'b0, 8'hD7);
    check_writes("badcsum", b);
    checks++;
    if ({error, done, cpu_reset} !== 3'b101 || err_code !== 2'd2) begin errors++; $display("FAIL badcsum_status got er%b dn%b cr%b c%0d want 101 2", error, done, cpu_reset, err_code); end
  endtask
  task automatic test_too_long();
    int b;
    do_reset();
    b = nw;
    send(8'h04, 1'b0);
    send(8'h01, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({error, in_ready, busy, cpu_reset} !== 4'b1001 || err_code !== 2'd1) begin errors++; $display("FAIL toolong_status got er%b rdy%b bz%b cr%b c%0d want 1001 1", error, in_ready, busy, cpu_reset, err_code); end
    checks++;
    if (nw - b !== 0) begin errors++; $display("FAIL toolong_writes got %0d want 0", nw - b); end
  endtask
  task automatic test_timeout();
    int b, k = 0;
    do_reset();
    b = nw;
    for (int i = 0; i < 7; i++) send(frm[i], 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    while (!error && k < 300) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!error || cyc - last !== 100) begin errors++; $display("FAIL timeout_cycle got er%b after %0d want 1 after 100", error, cyc - last); end
    checks++;
    if (err_code !== 2'd3 || done !== 1'b0 || cpu_reset !== 1'b1) begin errors++; $display("FAIL timeout_status got c%0d dn%b cr%b want 3 0 1", err_code, done, cpu_reset); end
    checks++;
    if (nw - b !== 1) begin errors++; $display("FAIL timeout_writes got %0d want 1", nw - b); end
  endtask
  task automatic test_empty_and_mid_reset();
    int b;
    do_reset();
    b = nw;
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({done, error, cpu_reset} !== 3'b100 || nw - b !== 0) begin errors++; $display("FAIL empty_status got dn%b er%b cr%b w%0d want 100 0", done, error, cpu_reset, nw - b); end
    do_reset();
    for (int i = 0; i < 5; i++) send(frm[i], 1'b0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy got %b want 1", busy); end
    do_reset();
    checks++;
    if ({done, cpu_reset, busy, in_ready, error} !== 5'b01010 || mem_addr !== 16'd0) begin errors++; $display("FAIL midreset_status got dn%b cr%b bz%b rdy%b er%b a%h want 01010 0", done, cpu_reset, busy, in_ready, error, mem_addr); end
    b = nw;
    send_frame(1'b0, good_csum());
    check_writes("reload", b);
    checks++;
    if ({done, cpu_reset} !== 2'b10) begin errors++; $display("FAIL reload_status got dn%b cr%b want 10", done, cpu_reset); end
  endtask
  initial begin
    test_reset();
    test_load(1'b0);
    test_load(1'b1);
    test_bad_csum();
    test_too_long();
    test_timeout();
    test_empty_and_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
